// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq: sequential 8-to-3 priority encoder. Captures an 8-bit vector
// on start and emits the index of every set bit, highest first, over valid/ready.
// After the last index, done pulses for one cycle with the emitted count.
// Latency: the first code appears 1 cycle after the accepted start. Throughput is
// 1 code/cycle while ready_i stays high.
// Backpressure: with ready_i low, out/pend/count hold stable and nothing is dropped.
// Ports:
//   clk_i, rst_i (sync, active-high)  - clock and reset
//   in_i[7:0], en_i, start_i          - vector and capture request (IDLE only)
//   abort_i                           - synchronous abort to IDLE, no done
//   ready_i / valid_o, out_o[2:0]     - code handshake
//   busy_o, done_o, none_o, count_o   - job status
module encoder_8to3_seq (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] in_i,
  input  logic       en_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       ready_i,
  output logic [2:0] out_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       none_o,
  output logic [3:0] count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EMIT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [3:0] count_q, count_d;
  logic       none_q, none_d;

  logic [2:0] idx;
  logic [7:0] pend_clr;
  logic       accept;

  // Priority pick: the ascending scan lets higher set bits overwrite lower ones.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_q[i]) idx = 3'(i);
    end
  end

  assign valid_o  = (state_q == EMIT);
  assign out_o    = valid_o ? idx : 3'd0;
  assign busy_o   = (state_q == EMIT) || (state_q == DONE);
  assign done_o   = (state_q == DONE);
  assign none_o   = none_q;
  assign count_o  = count_q;
  assign accept   = valid_o && ready_i;
  assign pend_clr = pend_q & ~(8'b1 << idx);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    count_d = count_q;
    none_d  = none_q;

    case (state_q)
      IDLE: begin
        if (start_i && en_i) begin
          pend_d  = in_i;
          count_d = 4'd0;
          if (in_i != 8'd0) begin
            none_d  = 1'b0;
            state_d = EMIT;
          end else begin
            none_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      EMIT: begin
        if (accept) begin
          pend_d  = pend_clr;
          count_d = count_q + 4'd1;
          if (pend_clr == 8'd0) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides any capture or accept on the same edge; the code being
    // accepted at that edge is not counted.
    if (abort_i) begin
      state_d = IDLE;
      pend_d  = 8'd0;
      count_d = count_q;
      none_d  = none_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= 8'd0;
      count_q <= 4'd0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb_encoder_8to3_seq: directed bench for encoder_8to3_seq.
// Inputs change 1 time unit after each rising edge, and outputs are sampled there.
// Each scenario task holds its own hand-computed expectations.
module tb_encoder_8to3_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] in_i = 8'd0;
  logic       en_i = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [2:0] out_o;
  logic       valid_o;
  logic       busy_o;
  logic       done_o;
  logic       none_o;
  logic [3:0] count_o;

  int total = 0;
  int bad = 0;

  encoder_8to3_seq dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_i    (in_i),
    .en_i    (en_i),
    .start_i (start_i),
    .abort_i (abort_i),
    .ready_i (ready_i),
    .out_o   (out_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .none_o  (none_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    total++;
    if ({out_o, valid_o, busy_o, done_o, none_o, count_o} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got out=%0d v=%0d b=%0d d=%0d n=%0d c=%0d exp all 0",
               out_o, valid_o, busy_o, done_o, none_o, count_o);
    end
    total++;
    if (dut.state_q !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d exp=0", dut.state_q);
    end

    // Reset partway through a full job, after 3 codes have been accepted.
    in_i = 8'hFF; en_i = 1'b1; start_i = 1'b1; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    total++;
    if (count_o !== 4'd3 || out_o !== 3'd4) begin
      bad++;
      $display("FAIL reset_pre got count=%0d out=%0d exp count=3 out=4", count_o, out_o);
    end
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    total++;
    if ({out_o, valid_o, busy_o, done_o, none_o, count_o} !== 11'd0 ||
        dut.state_q !== 2'd0 || dut.pend_q !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid got out=%0d v=%0d b=%0d d=%0d c=%0d st=%0d pend=%h exp all 0",
               out_o, valid_o, busy_o, done_o, count_o, dut.state_q, dut.pend_q);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (done_o !== 1'b0 || valid_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_done cyc=%0d got done=%0d valid=%0d exp 0 0", i, done_o, valid_o);
      end
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_codes [3];
    exp_codes[0] = 3'd7; exp_codes[1] = 3'd5; exp_codes[2] = 3'd2;
    in_i = 8'b1010_0100; en_i = 1'b1; start_i = 1'b1; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid_o !== 1'b1 || out_o !== exp_codes[i] || busy_o !== 1'b1) begin
        bad++;
        $display("FAIL basic_code%0d got v=%0d out=%0d b=%0d exp v=1 out=%0d b=1",
                 i, valid_o, out_o, busy_o, exp_codes[i]);
      end
      tick();
    end
    total++;
    if (done_o !== 1'b1 || none_o !== 1'b0 || count_o !== 4'd3 || valid_o !== 1'b0 ||
        busy_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_done got d=%0d n=%0d c=%0d v=%0d b=%0d exp d=1 n=0 c=3 v=0 b=1",
               done_o, none_o, count_o, valid_o, busy_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || count_o !== 4'd3) begin
      bad++;
      $display("FAIL basic_idle got b=%0d d=%0d c=%0d exp b=0 d=0 c=3", busy_o, done_o, count_o);
    end
  endtask

  task automatic test_backpressure();
    in_i = 8'h81; en_i = 1'b1; start_i = 1'b1; ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid_o !== 1'b1 || out_o !== 3'd7 || count_o !== 4'd0) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%0d out=%0d c=%0d exp v=1 out=7 c=0",
                 i, valid_o, out_o, count_o);
      end
      tick();
    end
    ready_i = 1'b1;
    total++;
    if (valid_o !== 1'b1 || out_o !== 3'd7) begin
      bad++;
      $display("FAIL bp_accept7 got v=%0d out=%0d exp v=1 out=7", valid_o, out_o);
    end
    tick();
    total++;
    if (valid_o !== 1'b1 || out_o !== 3'd0 || count_o !== 4'd1) begin
      bad++;
      $display("FAIL bp_code0 got v=%0d out=%0d c=%0d exp v=1 out=0 c=1", valid_o, out_o, count_o);
    end
    tick();
    total++;
    if (done_o !== 1'b1 || count_o !== 4'd2 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_done got d=%0d c=%0d v=%0d exp d=1 c=2 v=0", done_o, count_o, valid_o);
    end
    tick();
  endtask

  task automatic test_zero_gating();
    in_i = 8'h10; en_i = 1'b0; start_i = 1'b1; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0 || done_o !== 1'b0 || count_o !== 4'd2) begin
        bad++;
        $display("FAIL gate_idle%0d got b=%0d v=%0d d=%0d c=%0d exp b=0 v=0 d=0 c=2",
                 i, busy_o, valid_o, done_o, count_o);
      end
      tick();
    end
    in_i = 8'h00; en_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || none_o !== 1'b1 || valid_o !== 1'b0 || count_o !== 4'd0 ||
        busy_o !== 1'b1) begin
      bad++;
      $display("FAIL zero_done got d=%0d n=%0d v=%0d c=%0d b=%0d exp d=1 n=1 v=0 c=0 b=1",
               done_o, none_o, valid_o, count_o, busy_o);
    end
    tick();
    total++;
    if (done_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0 || none_o !== 1'b1) begin
      bad++;
      $display("FAIL zero_after got d=%0d v=%0d b=%0d n=%0d exp d=0 v=0 b=0 n=1",
               done_o, valid_o, busy_o, none_o);
    end
  endtask

  task automatic test_full();
    in_i = 8'hFF; en_i = 1'b1; start_i = 1'b1; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      total++;
      if (valid_o !== 1'b1 || out_o !== 3'(i)) begin
        bad++;
        $display("FAIL full_code got v=%0d out=%0d exp v=1 out=%0d", valid_o, out_o, i);
      end
      if (i == 5) begin
        start_i = 1'b1;
        in_i = 8'h01;
      end
      tick();
      start_i = 1'b0;
    end
    total++;
    if (done_o !== 1'b1 || count_o !== 4'd8 || none_o !== 1'b0) begin
      bad++;
      $display("FAIL full_done got d=%0d c=%0d n=%0d exp d=1 c=8 n=0", done_o, count_o, none_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || count_o !== 4'd8) begin
      bad++;
      $display("FAIL full_idle got b=%0d v=%0d c=%0d exp b=0 v=0 c=8", busy_o, valid_o, count_o);
    end
  endtask

  task automatic test_back_to_back();
    // start held high through DONE is taken in the IDLE cycle that follows.
    in_i = 8'h01; en_i = 1'b1; start_i = 1'b1; ready_i = 1'b1;
    tick();
    total++;
    if (valid_o !== 1'b1 || out_o !== 3'd0) begin
      bad++;
      $display("FAIL b2b_code got v=%0d out=%0d exp v=1 out=0", valid_o, out_o);
    end
    tick();
    total++;
    if (done_o !== 1'b1 || count_o !== 4'd1) begin
      bad++;
      $display("FAIL b2b_done got d=%0d c=%0d exp d=1 c=1", done_o, count_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got b=%0d v=%0d exp b=0 v=0", busy_o, valid_o);
    end
    tick();
    start_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || count_o !== 4'd0) begin
      bad++;
      $display("FAIL b2b_restart got v=%0d c=%0d exp v=1 c=0", valid_o, count_o);
    end
    tick();
    tick();
  endtask

  task automatic test_abort();
    in_i = 8'h0F; en_i = 1'b1; start_i = 1'b1; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || out_o !== 3'd3) begin
      bad++;
      $display("FAIL abort_first got v=%0d out=%0d exp v=1 out=3", valid_o, out_o);
    end
    tick();
    total++;
    if (out_o !== 3'd2 || count_o !== 4'd1) begin
      bad++;
      $display("FAIL abort_second got out=%0d c=%0d exp out=2 c=1", out_o, count_o);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || count_o !== 4'd1 ||
        dut.pend_q !== 8'd0 || dut.state_q !== 2'd0) begin
      bad++;
      $display("FAIL abort_idle got v=%0d b=%0d d=%0d c=%0d pend=%h st=%0d exp v=0 b=0 d=0 c=1 pend=00 st=0",
               valid_o, busy_o, done_o, count_o, dut.pend_q, dut.state_q);
    end
    tick();
    total++;
    if (done_o !== 1'b0 || count_o !== 4'd1) begin
      bad++;
      $display("FAIL abort_no_done got d=%0d c=%0d exp d=0 c=1", done_o, count_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_gating();
    test_full();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/encoder_8to3_seq.md
# encoder_8to3_seq

Sequential 8-to-3 priority encoder, the inverse of the team's 3-to-8 decoder. It captures an 8-bit one-hot or multi-hot vector on `start`. It then emits the 3-bit index of every set bit, highest index first, over a valid/ready handshake. After the last index it raises a one-cycle `done` together with the count of codes emitted. It sits between request/flag sources and any consumer that needs binary line numbers one at a time.

## Interface
- No parameters; widths are fixed at 8 inputs, 3-bit code and 4-bit count.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in` input 8: vector to encode, sampled only on an accepted start.
- `en` input 1: qualifies `start`. When `en`=0, `start` is ignored.
- `start` input 1: capture request, honoured only in IDLE.
- `abort` input 1: synchronous abort. Returns to IDLE, no `done`.
- `ready` input 1: consumer accepts `out` when `valid`=1.
- `out` output 3: index of the highest set pending bit. Forced to 0 when `valid`=0.
- `valid` output 1: `out` holds a code.
- `busy` output 1: high in EMIT and DONE.
- `done` output 1: one-cycle pulse at the end of a job.
- `none` output 1: qualifies `done`; high when the captured vector was 0.
- `count` output 4: codes accepted in the current or last job (0–8).

## Operation
- Registers:
  - `pend[7:0]`.
  - `count[3:0]`.
  - `none`.
  - `state`, with states IDLE, EMIT and DONE.
- `out` is combinational from `pend`: priority 7 down to 0, gated by `valid`.
- IDLE:
  - `valid`=0 and `busy`=0.
  - On `start`&`en`: `pend`<=`in`, `count`<=0.
    - If `in`!=0: `none`<=0 and go to EMIT.
    - If `in`==0: `none`<=1 and go to DONE.
  - `count` and `none` hold their last-job values while idle.
- EMIT:
  - `valid`=1 and `busy`=1.
  - On `valid`&`ready`: clear `pend[out]` and `count`<=`count`+1.
  - If the remaining pend is 0 after that clear, go to DONE.
  - When `ready`=0: `out`, `pend` and `count` are held stable.
  - `start`, `en` and `in` are ignored.
- DONE:
  - `done`=1, `busy`=1, `valid`=0.
  - Unconditionally go to IDLE on the next edge.
- `abort` has priority over everything except `rst`.
  - In any state: go to IDLE, `pend`<=0, no `done`.
  - `count` keeps the number accepted so far.
- `rst` has the highest priority.
- `in` changing mid-job has no effect.

## Timing
- Reset values:
  - `state`=IDLE, `pend`=0.
  - `out`=0, `valid`=0, `busy`=0, `done`=0, `none`=0, `count`=0.
- Start sampled at edge N:
  - `valid` is high from cycle N+1.
  - The first `out` is valid in cycle N+1, so start-to-first-code latency is 1 cycle.
- Each accept happens at an edge. The next index is visible in the following cycle, so the throughput is 1 code/cycle with `ready` held at 1.
- A job with k set bits and `ready`=1 throughout:
  - `valid` is high for cycles N+1..N+k.
  - `done` is in cycle N+k+1.
  - `busy` falls in cycle N+k+2.
- Zero vector: `done`=1 and `none`=1 in cycle N+1, `valid` never high.
- `start` held high across the DONE cycle is honoured in the IDLE cycle after it. The minimum start-to-start spacing is k+2 cycles.
- Simultaneous `abort` and accept on the same edge: abort wins. That code is not counted.
- `count` reaches 8 for `in`=8'hFF without wrap.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles mid-EMIT (in=8'hFF, 3 codes accepted).
  - Required response: next cycle all outputs are 0, `state` is IDLE, and no `done` follows.
- **Basic job:**
  - Stimulus: in=8'b1010_0100, start at N, `ready`=1.
  - Required response: `out` is 7, 5, 2 in cycles N+1..N+3. Then `done`=1, `none`=0, `count`=3 in N+4.
- **Backpressure:**
  - Stimulus: in=8'h81, `ready`=0 for cycles N+1..N+3, then 1.
  - Required response: `out`=7 is held stable. Then 7 is accepted in N+4, `out`=0 with `valid` in N+5, and `done` in N+6 with `count`=2.
- **Zero and gating:**
  - Stimulus: `start` with `en`=0 and in=8'h10.
  - Required response: nothing happens.
  - Stimulus: `start`, `en`=1, in=8'h00.
  - Required response: `done`=`none`=1 at N+1, `valid` stays 0, `count`=0.
- **Full vector and ignored start:**
  - Stimulus: in=8'hFF with `ready`=1, and `start` re-pulsed with in=8'h01 during EMIT.
  - Required response: `out` is 7..0 over 8 cycles and `count`=8; the mid-job start is ignored.
- **Abort:**
  - Stimulus: in=8'h0F, abort on the edge where the second code (2) is accepted.
  - Required response: IDLE next cycle, no `done`, `count`=1, `pend`=0.
